// File: rtl/jtcomsc_snd_pkg.sv
// Shared types and defaults for the Comsc main->sound command channel.
package jtcomsc_snd_pkg;

  // IRQ pulse generator states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_ACK   = 2'd2,
    ST_GAP   = 2'd3
  } irq_st_t;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_IRQ_LEN = 16;
  localparam int DEF_IRQ_GAP = 8;

endpackage

// File: rtl/jtcomsc_cmd_fifo.sv
// Command byte FIFO: storage, wrapping pointers, occupancy, full/empty and
// sticky overflow. Also exposes the entry behind the head so the owner can
// load its output latch in the same cycle as a pop.
module jtcomsc_cmd_fifo
  import jtcomsc_snd_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_din,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_one,
  output logic       o_overflow,
  output logic [7:0] o_nxt
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][7:0] r_mem;
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_cnt;
  logic                  r_ovf;
  logic [AW-1:0]         w_rd_nx;
  logic                  w_do_push, w_do_pop;

  assign o_empty    = (r_cnt == '0);
  assign o_full     = (r_cnt == FULL_CNT);
  assign o_one      = (r_cnt == (AW+1)'(1));
  assign o_overflow = r_ovf;
  assign w_rd_nx    = r_rd_ptr + AW'(1);
  assign o_nxt      = r_mem[w_rd_nx];

  // A push into a full FIFO is accepted only when a pop frees a slot the
  // same cycle; a pop from empty is ignored (even alongside a push).
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= w_rd_nx;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (i_push && !w_do_push) r_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/jtcomsc_snd_cmd.sv
// Main CPU -> sound board command channel. Edge-detects the CPU strobes,
// queues command bytes, presents the head on snd_latch and emits one
// snd_irq pulse per queued command with a guaranteed low gap between them.
// JTCOMSC_SNDCMD_FIFO_EN: when defined, a DEPTH-entry FIFO queues commands;
// otherwise a single register holds the latest command.
module jtcomsc_snd_cmd
  import jtcomsc_snd_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int IRQ_LEN = DEF_IRQ_LEN,
  parameter int IRQ_GAP = DEF_IRQ_GAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       main_wr,
  input  logic [7:0] main_din,
  input  logic       snd_rd,
  output logic [7:0] snd_latch,
  output logic       snd_irq,
  output logic       pending,
  output logic       full,
  output logic       overflow
);

  localparam logic [7:0] LEN_M1 = 8'(IRQ_LEN - 1);
  localparam logic [7:0] GAP_M1 = 8'(IRQ_GAP - 1);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      IRQ_LEN < 1 || IRQ_LEN > 255 || IRQ_GAP < 1 || IRQ_GAP > 255) begin : g_bad_cfg
    $error("jtcomsc_snd_cmd: parameter out of range");
  end

  logic       r_wr_l, r_rd_l;
  logic       w_push, w_pop, w_pend;
  logic [7:0] r_latch;

  // Previous-cycle strobe levels; cleared so a strobe held through reset
  // release still registers as a fresh edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_l <= 1'b0;
      r_rd_l <= 1'b0;
    end else begin
      r_wr_l <= main_wr;
      r_rd_l <= snd_rd;
    end
  end

  // Push on write start; pop on read end so the CPU reads a stable byte
  assign w_push = main_wr & ~r_wr_l;
  assign w_pop  = ~snd_rd & r_rd_l;

`ifdef JTCOMSC_SNDCMD_FIFO_EN
  logic       w_empty, w_full, w_one, w_ovf;
  logic [7:0] w_nxt;

  jtcomsc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_din      (main_din),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_one      (w_one),
    .o_overflow (w_ovf),
    .o_nxt      (w_nxt)
  );

  // Head latch: new head after a pop, first byte on push-to-empty, and the
  // last popped byte is held once the queue drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latch <= 8'h00;
    end else if (w_push && w_empty) begin
      r_latch <= main_din;
    end else if (w_pop && !w_empty) begin
      if (!w_one)      r_latch <= w_nxt;
      else if (w_push) r_latch <= main_din;
    end
  end

  assign w_pend   = ~w_empty;
  assign full     = w_full;
  assign overflow = w_ovf;
`else
  logic r_pend;

  // Single-entry mode: a write always replaces the command; a write in the
  // same cycle as a read end keeps the new command pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latch <= 8'h00;
      r_pend  <= 1'b0;
    end else begin
      if (w_push) begin
        r_latch <= main_din;
        r_pend  <= 1'b1;
      end else if (w_pop) begin
        r_pend  <= 1'b0;
      end
    end
  end

  assign w_pend   = r_pend;
  assign full     = r_pend;
  assign overflow = 1'b0;
`endif

  assign snd_latch = r_latch;
  assign pending   = w_pend;

  irq_st_t    r_st, w_st_nx;
  logic [7:0] r_cnt, w_cnt_nx;
  logic       r_acked, w_acked_nx;
  logic       w_irq;

  // IRQ FSM state, phase counter and early-acknowledge flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st    <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_acked <= 1'b0;
    end else begin
      r_st    <= w_st_nx;
      r_cnt   <= w_cnt_nx;
      r_acked <= w_acked_nx;
    end
  end

  // Next state: a full-length pulse, wait for the read (or one seen during
  // the pulse), then a fixed low gap before the next command may fire
  always_comb begin
    w_st_nx    = r_st;
    w_cnt_nx   = r_cnt;
    w_acked_nx = r_acked;
    w_irq      = 1'b0;
    case (r_st)
      ST_IDLE: begin
        if (w_pend) begin
          w_st_nx  = ST_PULSE;
          w_cnt_nx = 8'd0;
        end
      end
      ST_PULSE: begin
        w_irq = 1'b1;
        if (w_pop) w_acked_nx = 1'b1;
        if (r_cnt == LEN_M1) begin
          w_st_nx  = ST_ACK;
          w_cnt_nx = 8'd0;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      ST_ACK: begin
        if (w_pop || r_acked) begin
          w_st_nx    = ST_GAP;
          w_acked_nx = 1'b0;
          w_cnt_nx   = 8'd0;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_M1) begin
          w_st_nx  = ST_IDLE;
          w_cnt_nx = 8'd0;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      default: w_st_nx = ST_IDLE;
    endcase
  end

  assign snd_irq = w_irq;

endmodule
